// File: rtl/data_mem_responder.sv
// data_mem_responder: responder end of the data-memory interface.
// Accepts one load/store at a time, commits it after a fixed LATENCY and
// holds the response until the initiator takes it.
module data_mem_responder #(
   parameter int DATA_WIDTH  = 32,
   parameter int ENTRY_COUNT = 32,
   parameter int LATENCY     = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [31:0]           req_addr,
   input  logic                  req_wr_en,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [3:0]            req_be,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err
);

   localparam int         IDX_W  = (ENTRY_COUNT > 1) ? $clog2(ENTRY_COUNT) : 1;
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic [3:0]            cnt;
   logic [31:0]           cap_addr;
   logic                  cap_wr_en;
   logic [DATA_WIDTH-1:0] cap_wdata;
   logic [3:0]            cap_be;

   logic [DATA_WIDTH-1:0] mem [ENTRY_COUNT];

   logic                  enter_resp;
   logic [31:0]           cur_addr;
   logic                  cur_wr_en;
   logic [DATA_WIDTH-1:0] cur_wdata;
   logic [3:0]            cur_be;
   logic                  cur_err;
   logic [IDX_W-1:0]      cur_idx;

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (req_valid) state_nxt = (LATENCY == 1) ? RESP : WAIT;
         WAIT: if (cnt == 4'd1) state_nxt = RESP;
         RESP: if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Commit happens on the edge entering RESP; with LATENCY=1 that is the
   // acceptance edge itself, so the live request fields are used there.
   always_comb begin
      enter_resp = (state != RESP) && (state_nxt == RESP);
      if (state == IDLE) begin
         cur_addr  = req_addr;
         cur_wr_en = req_wr_en;
         cur_wdata = req_wdata;
         cur_be    = req_be;
      end else begin
         cur_addr  = cap_addr;
         cur_wr_en = cap_wr_en;
         cur_wdata = cap_wdata;
         cur_be    = cap_be;
      end
      cur_err = (cur_addr[1:0] != 2'b00) || (cur_addr[31:2] >= 30'(ENTRY_COUNT));
      cur_idx = cur_addr[IDX_W+1:2];
   end

   // Request capture and latency counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         cap_addr  <= '0;
         cap_wr_en <= 1'b0;
         cap_wdata <= '0;
         cap_be    <= '0;
      end else begin
         if (state == IDLE && req_valid) begin
            cap_addr  <= req_addr;
            cap_wr_en <= req_wr_en;
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
            cnt       <= (LATENCY == 1) ? 4'd0 : LAT_M1;
         end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   // Response registers, held until the handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (enter_resp) begin
         rsp_err   <= cur_err;
         rsp_rdata <= (!cur_err && !cur_wr_en) ? mem[cur_idx] : '0;
      end
   end

   // Storage array (not reset); byte-lane masked store.
   always_ff @(posedge clk) begin
      if (enter_resp && !rst && cur_wr_en && !cur_err) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed and random transactions
// against a word-array reference model, plus a LATENCY=1 instance.
module tb_data_mem_responder;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   logic        req_valid, req_ready, req_wr_en, rsp_valid, rsp_ready, rsp_err;
   logic [31:0] req_addr, req_wdata, rsp_rdata;
   logic [3:0]  req_be;

   logic        l1_req_valid, l1_req_ready, l1_req_wr_en, l1_rsp_valid, l1_rsp_ready, l1_rsp_err;
   logic [31:0] l1_req_addr, l1_req_wdata, l1_rsp_rdata;
   logic [3:0]  l1_req_be;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] ref_mem [32];

   data_mem_responder #(.DATA_WIDTH(32), .ENTRY_COUNT(32), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wr_en(req_wr_en), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err)
   );

   data_mem_responder #(.DATA_WIDTH(32), .ENTRY_COUNT(32), .LATENCY(1)) dut_l1 (
      .clk(clk), .rst(rst),
      .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_addr(l1_req_addr),
      .req_wr_en(l1_req_wr_en), .req_wdata(l1_req_wdata), .req_be(l1_req_be),
      .rsp_valid(l1_rsp_valid), .rsp_ready(l1_rsp_ready), .rsp_rdata(l1_rsp_rdata),
      .rsp_err(l1_rsp_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: applies the request to ref_mem and returns the response.
   task automatic model(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] exp_rdata,
                        output logic exp_err);
      int unsigned idx;
      logic [31:0] mask;
      idx       = a / 4;
      exp_err   = (a % 4 != 0) || (idx >= 32);
      exp_rdata = 32'h0;
      if (!exp_err) begin
         if (!w) exp_rdata = ref_mem[idx];
         else begin
            mask = 32'h0;
            for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
            ref_mem[idx] = (ref_mem[idx] & ~mask) | (d & mask);
         end
      end
   endtask

   // One full transaction on the LATENCY=2 instance, with bp cycles of backpressure.
   task automatic xact(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] be, input int bp);
      logic [31:0] er;
      logic        ee;
      int          k;
      model(a, w, d, be, er, ee);
      @(negedge clk);
      check("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_addr = a; req_wr_en = w; req_wdata = d; req_be = be;
      rsp_ready = 1'b0;
      @(posedge clk);
      k = 0;
      do begin
         @(negedge clk);
         k++;
         if (k == 1) begin
            req_valid = 1'b0; req_addr = $urandom; req_wr_en = ~w;
            req_wdata = $urandom; req_be = 4'($urandom);
         end
      end while (rsp_valid !== 1'b1 && k < 20);
      check("latency", 32'(k), 32'(LAT));
      check("rsp_rdata", rsp_rdata, er);
      check("rsp_err", 32'(rsp_err), 32'(ee));
      repeat (bp) begin
         @(negedge clk);
         check("bp_valid", 32'(rsp_valid), 32'd1);
         check("bp_rdata", rsp_rdata, er);
         check("bp_err", 32'(rsp_err), 32'(ee));
         check("bp_req_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("post_hs_valid", 32'(rsp_valid), 32'd0);
      check("post_hs_req_ready", 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] er, a, dval;
      logic        ee;
      int          k;

      for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
      rst = 1'b1;
      req_valid = 0; req_addr = 0; req_wr_en = 0; req_wdata = 0; req_be = 0; rsp_ready = 0;
      l1_req_valid = 0; l1_req_addr = 0; l1_req_wr_en = 0; l1_req_wdata = 0; l1_req_be = 0;
      l1_rsp_ready = 0;
      repeat (2) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_l1_req_ready", 32'(l1_req_ready), 32'd1);
      check("rst_l1_rsp_valid", 32'(l1_rsp_valid), 32'd0);
      rst = 1'b0;

      // Fill every word so the model starts from known contents.
      for (int i = 0; i < 32; i++) xact(32'(i * 4), 1'b1, $urandom, 4'hF, 0);

      // Store then load.
      xact(32'h8, 1'b1, 32'hDEADBEEF, 4'hF, 0);
      xact(32'h8, 1'b0, 32'h0, 4'h0, 0);
      // Byte enables.
      xact(32'hC, 1'b1, 32'h11223344, 4'hF, 0);
      xact(32'hC, 1'b1, 32'hAABBCCDD, 4'b0101, 0);
      xact(32'hC, 1'b0, 32'h0, 4'hF, 0);
      // Errors.
      xact(32'h6, 1'b0, 32'h0, 4'hF, 0);
      xact(32'h80, 1'b1, 32'h55555555, 4'hF, 0);
      xact(32'h7C, 1'b0, 32'h0, 4'hF, 0);
      // Backpressure and a byte-enable-free store.
      xact(32'h8, 1'b0, 32'h0, 4'h0, 5);
      xact(32'h10, 1'b1, 32'h89ABCDEF, 4'h0, 2);
      xact(32'h10, 1'b0, 32'h0, 4'h0, 0);

      // Reset while waiting: the store must be dropped.
      xact(32'h4, 1'b1, 32'h0, 4'hF, 0);
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h4; req_wr_en = 1'b1; req_wdata = 32'h12345678; req_be = 4'hF;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("rstwait_valid", 32'(rsp_valid), 32'd0);
         check("rstwait_req_ready", 32'(req_ready), 32'd1);
      end
      xact(32'h4, 1'b0, 32'h0, 4'hF, 0);

      // Reset during the response: the write already landed.
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h18; req_wr_en = 1'b1; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
      model(32'h18, 1'b1, 32'hCAFEF00D, 4'hF, er, ee);
      @(posedge clk);
      k = 0;
      do begin
         @(negedge clk);
         k++;
         req_valid = 1'b0;
      end while (rsp_valid !== 1'b1 && k < 20);
      check("rstresp_latency", 32'(k), 32'(LAT));
      rst = 1'b1;
      #1;
      check("rstresp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      xact(32'h18, 1'b0, 32'h0, 4'hF, 0);

      // Random traffic, occasionally misaligned or out of range.
      for (int i = 0; i < 60; i++) begin
         a = 32'($urandom_range(0, 39)) * 4;
         if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
         xact(a, 1'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 3)));
      end

      // LATENCY=1 instance: back-to-back with valid and ready held high.
      dval = $urandom;
      @(negedge clk);
      l1_req_valid = 1'b1; l1_req_wr_en = 1'b1; l1_req_addr = 32'h14;
      l1_req_wdata = dval; l1_req_be = 4'hF; l1_rsp_ready = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         l1_req_wr_en = 1'b0;
         check("l1_rsp_valid", 32'(l1_rsp_valid), 32'(c % 2));
         check("l1_req_ready", 32'(l1_req_ready), 32'((c + 1) % 2));
         if (c % 2 == 1) begin
            check("l1_rsp_rdata", l1_rsp_rdata, (c == 1) ? 32'h0 : dval);
            check("l1_rsp_err", 32'(l1_rsp_err), 32'd0);
         end
      end
      l1_req_valid = 1'b0;
      l1_rsp_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Responder end of the CPU's data-memory interface. It accepts one load/store request at a time over a valid/ready request channel and holds a word-addressed storage array. It returns a response after a fixed programmable latency over a valid/ready response channel. It replaces the zero-latency data memory in the MEM stage, so the pipeline can be exercised against realistic multi-cycle memory with backpressure.

Parameters:
DATA_WIDTH, 32, data word width; fixed at 32 (byte enables are 4 lanes)
ENTRY_COUNT, 32, number of words in the storage array
LATENCY, 2, cycles from request acceptance edge to rsp_valid assertion; legal range 1..15

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  initiator presents a request
req_ready  output  1  responder can accept a request this cycle
req_addr  input  32  byte address; word index = req_addr[31:2]
req_wr_en  input  1  1 = store, 0 = load
req_wdata  input  32  store data
req_be  input  4  store byte enables; bit i enables byte lane i (bits 8i+7:8i)
rsp_valid  output  1  response available
rsp_ready  input  1  initiator accepts the response this cycle
rsp_rdata  output  32  load data; 0 for stores and errors
rsp_err  output  1  request was misaligned or out of range

Behaviour:
- Reset, asynchronous: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
- req_ready=1 in IDLE, including while rst is held. Storage contents are not reset.
- States:
  - IDLE: req_ready=1. On a rising edge with req_valid=1, capture addr/wr_en/wdata/be.
    - LATENCY=1: go to RESP.
    - Otherwise: go to WAIT with counter=LATENCY-1.
  - WAIT: req_ready=0. Counter decrements each edge. At the edge where counter=1, go to RESP.
  - RESP: req_ready=0, rsp_valid=1. On an edge with rsp_ready=1, go to IDLE.
- Timing: request accepted at edge N -> rsp_valid=1 in the cycle after edge N+LATENCY-1. The response is visible for the first time LATENCY cycles after acceptance.
- Commit: the store write and the load read both happen at the edge that enters RESP. rsp_rdata/rsp_err are registered at that same edge.
- Response stability: rsp_rdata and rsp_err are held stable while rsp_valid=1 and rsp_ready=0, for unbounded backpressure.
- No back-to-back handshakes: after the response handshake edge, req_ready rises in the following cycle (IDLE). Minimum request period is LATENCY+1 cycles.
- Request inputs are ignored outside IDLE. Captured values are used, so the initiator may change req_* after acceptance.
- Error condition: req_addr[1:0]!=0 or req_addr[31:2] >= ENTRY_COUNT.
  - Effect: rsp_err=1, rsp_rdata=0, no storage write, same latency as a normal access.
- Store, no error:
  - Only lanes with req_be set are updated.
  - req_be=4'b0000 is a legal no-op: rsp_err=0, rsp_rdata=0.
- Load, no error: returns the full word; req_be is ignored.
- Read-after-write: a load accepted after a store's response sees the stored value.
- Reset mid-operation:
  - If rst asserts in WAIT, the pending store is dropped (no write) and the response is never issued.
  - If rst asserts in RESP, the write has already committed; the response is discarded.
- Simultaneous events:
  - req_valid=1 in the same cycle as the RESP->IDLE handshake is not accepted; it is accepted the next cycle if still valid.
  - rsp_ready=1 while rsp_valid=0 has no effect.

Test Plan:
- LATENCY=2. Store addr=0x8, wdata=0xDEADBEEF, be=0xF; then load addr=0x8.
  - Required: store response rsp_err=0, rsp_rdata=0.
  - Required: load rsp_rdata=0xDEADBEEF, with rsp_valid first high exactly 2 cycles after each acceptance edge.
- Byte enables. Word 3 holds 0x11223344; store addr=0xC, wdata=0xAABBCCDD, be=4'b0101; then load 0xC.
  - Required: load returns 0x11BB33DD.
- Errors.
  - Load addr=0x6 -> rsp_err=1, rsp_rdata=0.
  - Store addr=0x80 (index 32, ENTRY_COUNT=32) -> rsp_err=1; then load 0x7C -> prior contents unchanged.
- Backpressure. Hold rsp_ready=0 for 5 cycles after rsp_valid rises.
  - Required: rsp_valid, rsp_rdata and rsp_err are constant.
  - Required: req_ready=0 throughout; req_ready=1 the cycle after the rsp_ready=1 edge.
- Reset in WAIT. Store 0x12345678 to addr=0x4 (prior value 0), pulse rst one cycle after acceptance.
  - Required: rsp_valid never rises and req_ready=1.
  - Required: a subsequent load of 0x4 returns 0.
- LATENCY=1 build. Issue back-to-back loads with req_valid held high and rsp_ready held high.
  - Required: accepts every 2 cycles, rsp_valid high every other cycle.
